imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Parametrised immediate-extension stage for the CPU datapath, placed between instruction decode and the ALU/branch operand mux.
- Widens an IN_W-bit immediate to OUT_W bits in one of four modes: zero, sign, upper-load and shifted branch offset.
- Registered, valid/ready handshaked and backed by a 2-entry skid buffer, so decode can stall or flush it without losing or duplicating operands.
- Carries a destination tag alongside each result.

Parameters:
- IN_W, 16: immediate input width.
- OUT_W, 32: extended output width; must satisfy OUT_W >= IN_W.
- SHIFT, 2: left shift applied in BRANCH mode; must satisfy SHIFT < OUT_W.
- TAG_W, 5: width of the sideband tag (register number) passed through unchanged.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  an immediate is presented.
- in_ready  output  1  stage can accept this cycle.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  0=ZERO, 1=SIGN, 2=UPPER, 3=BRANCH.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  OUT_W  extended immediate.
- out_tag  output  TAG_W  tag of the entry in out_data.
- out_ovf  output  1  BRANCH-mode bits were lost by truncation.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n). While rst_n=0:
  - entry count = 0, out_valid=0, out_data=0, out_tag=0, out_ovf=0.
  - in_ready=1, because it is derived from count.
- Extension function, computed combinationally at the input and stored as the already-extended value:
  - ZERO: {(OUT_W-IN_W) zeros, in_imm}.
  - SIGN: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
  - UPPER: in_imm placed in bits [OUT_W-1 : OUT_W-IN_W], lower bits zero. If OUT_W < 2*IN_W, only the low OUT_W-IN_W zeros are inserted; never wider than OUT_W.
  - BRANCH: sign-extend to OUT_W+SHIFT bits, shift left by SHIFT, keep the low OUT_W bits.
  - out_ovf=1 only in BRANCH mode, and only when the discarded top SHIFT bits are not all equal to the new bit OUT_W-1. Otherwise out_ovf=0.
- Buffer and handshake:
  - Two-entry FIFO (head = output register, tail = skid); count ranges 0..2.
  - in_ready = (count < 2). It is registered-state based and has no combinational path from out_ready.
  - Accept when in_valid && in_ready. Pop when out_valid && out_ready.
  - out_valid = (count > 0). out_data, out_tag and out_ovf always present the head entry.
  - Latency: an accepted entry into an empty buffer appears on out_* the next cycle.
  - Throughput: one result per cycle while out_ready stays high.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged. The tail (or the new entry) moves to the head, in order.
  - Push with count=2 cannot occur, because in_ready=0.
  - Pop with count=0 cannot occur, because out_valid=0.
  - Ordering is strictly FIFO; no entry is reordered or duplicated.
- Flush:
  - flush=1 sets count=0 on the next edge and clears out_valid.
  - An input presented in the same cycle as flush is dropped.
  - A pop in the same cycle as flush is still a valid transfer for the consumer.
- Held state: out_data and out_tag hold their last value when count becomes 0. Only reset zeroes them.
- Reset mid-operation: the asynchronous clear applies immediately. No partial entry survives.

Decomposition:
- Shared package/header imm_ext_defs holds:
  - mode encodings IMM_ZERO=2'd0, IMM_SIGN=2'd1, IMM_UPPER=2'd2, IMM_BRANCH=2'd3;
  - default widths 16/32.
- One combinational sub-module, imm_extend_core (parameters IN_W, OUT_W, SHIFT):
  - inputs imm and mode; outputs value and ovf.
  - Instantiated once at the input; the FIFO and control live in the top level.

Test Plan:
- Reset then release, idle -> out_valid=0, out_data=0, in_ready=1. Then push imm=16'h8001 mode SIGN tag 3 -> next cycle out_data=32'hFFFF8001, out_tag=3, out_ovf=0.
- Modes on imm=16'hF234, out_ready=1:
  - ZERO -> 32'h0000F234.
  - UPPER -> 32'hF2340000.
  - BRANCH -> 32'hFFFFC8D0, out_ovf=0.
- BRANCH overflow with OUT_W=16, SHIFT=2, imm=16'h4000 -> out_data=16'h0000, out_ovf=1.
- Backpressure: out_ready=0, push A then B -> in_ready=0 after two pushes. Then raise out_ready -> A then B emerge on consecutive cycles and in_ready returns to 1.
- Simultaneous push/pop: count=1, push C while popping -> count stays 1 and C is the next head. Streaming 8 entries back to back gives 8 outputs in order with no bubble.
- Flush with count=2 plus a concurrent push -> out_valid=0 next cycle and in_ready=1; none of the three entries appear later. Asserting rst_n=0 mid-stream clears out_valid asynchronously, before the next clock edge.

Source files
------------

// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and default widths.
// Latency: none (declarations only).
// Backpressure: not applicable.
package imm_ext_defs;

  // Extension modes as driven on in_mode by decode
  typedef enum logic [1:0] {
    IMM_ZERO   = 2'd0,
    IMM_SIGN   = 2'd1,
    IMM_UPPER  = 2'd2,
    IMM_BRANCH = 2'd3
  } imm_mode_e;

  // Default widths for the 32-bit datapath
  localparam int IMM_IN_W_DEF  = 16;
  localparam int IMM_OUT_W_DEF = 32;
  localparam int IMM_SHIFT_DEF = 2;
  localparam int IMM_TAG_W_DEF = 5;

  // Head register plus one skid entry
  localparam logic [1:0] FIFO_DEPTH = 2'd2;

  // True when the two-entry buffer still has room
  function automatic logic fifo_has_room(input logic [1:0] count);
    return (count < FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational widening of an immediate in zero/sign/upper/branch-offset modes.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module imm_extend_core
  import imm_ext_defs::*;
#(
  parameter int IN_W  = IMM_IN_W_DEF,
  parameter int OUT_W = IMM_OUT_W_DEF,
  parameter int SHIFT = IMM_SHIFT_DEF
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] value,
  output logic             ovf
);

  logic [OUT_W-1:0]       zext;
  logic [OUT_W-1:0]       sext;
  logic [OUT_W-1:0]       upper;
  logic [OUT_W-1:0]       branch;
  logic [OUT_W+SHIFT-1:0] wide_sext;
  logic [OUT_W+SHIFT-1:0] wide_shl;
  logic                   br_ovf;

  // Zero- and sign-extended forms of the raw immediate
  always_comb begin
    zext            = '0;
    zext[IN_W-1:0]  = imm;
    sext            = {OUT_W{imm[IN_W-1]}};
    sext[IN_W-1:0]  = imm;
  end

  // Upper-load: immediate occupies the top IN_W bits, zeros below
  always_comb begin
    upper                  = '0;
    upper[OUT_W-1 -: IN_W] = imm;
  end

  // Branch offset: sign-extend into a SHIFT-wider word, shift, keep the low OUT_W bits
  always_comb begin
    wide_sext           = {(OUT_W+SHIFT){imm[IN_W-1]}};
    wide_sext[IN_W-1:0] = imm;
    wide_shl            = wide_sext << SHIFT;
    branch              = wide_shl[OUT_W-1:0];
  end

  // Overflow when the bits shifted out disagree with the new sign bit
  generate
    if (SHIFT == 0) begin : g_no_shift
      assign br_ovf = 1'b0;
    end else begin : g_shift
      assign br_ovf = (wide_shl[OUT_W+SHIFT-1 -: SHIFT] != {SHIFT{branch[OUT_W-1]}});
    end
  endgenerate

  // Mode select; only branch mode can report lost bits
  always_comb begin
    value = zext;
    ovf   = 1'b0;
    unique case (imm_mode_e'(mode))
      IMM_ZERO:   value = zext;
      IMM_SIGN:   value = sext;
      IMM_UPPER:  value = upper;
      IMM_BRANCH: begin
        value = branch;
        ovf   = br_ovf;
      end
      default: begin
        value = zext;
        ovf   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer and tag sideband.
// Latency: 1 cycle from accepted input to out_valid; 1 result/cycle sustained.
// Backpressure: in_ready = room in buffer (registered count only, no path from out_ready).
module imm_extend_pipe
  import imm_ext_defs::*;
#(
  parameter int IN_W  = IMM_IN_W_DEF,
  parameter int OUT_W = IMM_OUT_W_DEF,
  parameter int SHIFT = IMM_SHIFT_DEF,
  parameter int TAG_W = IMM_TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);

  logic [OUT_W-1:0] ext_value;
  logic             ext_ovf;

  logic [1:0]       count_q,     count_d;
  logic [OUT_W-1:0] head_data_q, head_data_d;
  logic [TAG_W-1:0] head_tag_q,  head_tag_d;
  logic             head_ovf_q,  head_ovf_d;
  logic [OUT_W-1:0] tail_data_q, tail_data_d;
  logic [TAG_W-1:0] tail_tag_q,  tail_tag_d;
  logic             tail_ovf_q,  tail_ovf_d;

  logic push;
  logic pop;

  imm_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_core (
    .imm   (in_imm),
    .mode  (in_mode),
    .value (ext_value),
    .ovf   (ext_ovf)
  );

  assign in_ready  = fifo_has_room(count_q);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_tag   = head_tag_q;
  assign out_ovf   = head_ovf_q;

  // A push during flush is dropped; a pop during flush still completes for the consumer
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;

  // Buffer next state: head always holds the oldest entry, tail the second
  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_tag_d  = head_tag_q;
    head_ovf_d  = head_ovf_q;
    tail_data_d = tail_data_q;
    tail_tag_d  = tail_tag_q;
    tail_ovf_d  = tail_ovf_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case (count_q)
        2'd0: begin
          if (push) begin
            head_data_d = ext_value;
            head_tag_d  = in_tag;
            head_ovf_d  = ext_ovf;
            count_d     = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data_d = ext_value;
            head_tag_d  = in_tag;
            head_ovf_d  = ext_ovf;
          end else if (push) begin
            tail_data_d = ext_value;
            tail_tag_d  = in_tag;
            tail_ovf_d  = ext_ovf;
            count_d     = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          // Full: in_ready is low, so only a pop can happen here
          if (pop) begin
            head_data_d = tail_data_q;
            head_tag_d  = tail_tag_q;
            head_ovf_d  = tail_ovf_q;
            count_d     = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  // State registers; reset clears everything, flush only clears the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_tag_q  <= '0;
      head_ovf_q  <= 1'b0;
      tail_data_q <= '0;
      tail_tag_q  <= '0;
      tail_ovf_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_tag_q  <= head_tag_d;
      head_ovf_q  <= head_ovf_d;
      tail_data_q <= tail_data_d;
      tail_tag_q  <= tail_tag_d;
      tail_ovf_q  <= tail_ovf_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: 32-bit default instance plus a 16-bit branch-overflow instance.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercised via out_ready stalls, skid fill, simultaneous push/pop and flush.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;

  // 32-bit output instance
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_ovf;

  // 16-bit output instance for truncation overflow
  logic        flush16;
  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] in_imm16;
  logic [1:0]  in_mode16;
  logic [4:0]  in_tag16;
  logic        out_valid16;
  logic        out_ready16;
  logic [15:0] out_data16;
  logic [4:0]  out_tag16;
  logic        out_ovf16;

  int n_checks;
  int n_errors;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2), .TAG_W(5)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf)
  );

  imm_extend_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(2), .TAG_W(5)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush16),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_imm    (in_imm16),
    .in_mode   (in_mode16),
    .in_tag    (in_tag16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_data  (out_data16),
    .out_tag   (out_tag16),
    .out_ovf   (out_ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [4:0] tag);
    in_valid = v;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
  endtask

  // Single push with the consumer ready, checked the cycle after and drained
  task automatic mode_case(input string name, input logic [15:0] imm, input logic [1:0] mode,
                           input logic [31:0] exp, input logic exp_ovf);
    out_ready = 1'b1;
    drive(1'b1, imm, mode, 5'd9);
    tick();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk({name, "_vld"}, 32'(out_valid), 32'd1);
    chk({name, "_dat"}, out_data, exp);
    chk({name, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    tick();
    chk({name, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  // Push into the 16-bit instance, consumer always ready
  task automatic case16(input string name, input logic [15:0] imm, input logic [1:0] mode,
                        input logic [15:0] exp, input logic exp_ovf);
    in_valid16 = 1'b1;
    in_imm16   = imm;
    in_mode16  = mode;
    tick();
    chk({name, "_vld"}, 32'(out_valid16), 32'd1);
    chk({name, "_dat"}, 32'(out_data16), 32'(exp));
    chk({name, "_ovf"}, 32'(out_ovf16), 32'(exp_ovf));
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    flush16     = 1'b0;
    in_valid16  = 1'b0;
    in_imm16    = 16'h0;
    in_mode16   = 2'd0;
    in_tag16    = 5'd2;
    out_ready16 = 1'b1;

    // In reset
    #3;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_dat", out_data, 32'h0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    #10;
    rst_n = 1'b1;
    tick();
    chk("idle_vld", 32'(out_valid), 32'd0);
    chk("idle_dat", out_data, 32'h0);
    chk("idle_rdy", 32'(in_ready), 32'd1);

    // First push, sign mode, one-cycle latency
    drive(1'b1, 16'h8001, 2'd1, 5'd3);
    tick();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("first_vld", 32'(out_valid), 32'd1);
    chk("first_dat", out_data, 32'hFFFF8001);
    chk("first_tag", 32'(out_tag), 32'd3);
    chk("first_ovf", 32'(out_ovf), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("first_pop", 32'(out_valid), 32'd0);

    // Modes
    mode_case("zero",    16'hF234, 2'd0, 32'h0000F234, 1'b0);
    mode_case("upper",   16'hF234, 2'd2, 32'hF2340000, 1'b0);
    mode_case("branch",  16'hF234, 2'd3, 32'hFFFFC8D0, 1'b0);
    mode_case("sign_p",  16'h7FFF, 2'd1, 32'h00007FFF, 1'b0);
    mode_case("branch_p",16'h7FFF, 2'd3, 32'h0001FFFC, 1'b0);

    // 16-bit output: truncated branch offsets
    case16("b16_4000", 16'h4000, 2'd3, 16'h0000, 1'b1);
    case16("b16_2000", 16'h2000, 2'd3, 16'h8000, 1'b1);
    case16("b16_ffff", 16'hFFFF, 2'd3, 16'hFFFC, 1'b0);
    case16("u16_1234", 16'h1234, 2'd2, 16'h1234, 1'b0);
    in_valid16 = 1'b0;
    tick();
    chk("b16_tag", 32'(out_tag16), 32'd2);

    // Backpressure: fill both entries
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 2'd0, 5'd1);
    tick();
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    drive(1'b1, 16'h2222, 2'd0, 5'd2);
    tick();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("bp_full", 32'(in_ready), 32'd0);
    chk("bp_headA", out_data, 32'h00001111);
    tick();
    chk("bp_hold", out_data, 32'h00001111);
    chk("bp_tagA", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_headB", out_data, 32'h00002222);
    chk("bp_tagB", 32'(out_tag), 32'd2);
    chk("bp_rdy2", 32'(in_ready), 32'd1);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_held", out_data, 32'h00002222);

    // Simultaneous push/pop at count=1
    out_ready = 1'b0;
    drive(1'b1, 16'h00D0, 2'd0, 5'd4);
    tick();
    out_ready = 1'b1;
    drive(1'b1, 16'h00C0, 2'd0, 5'd5);
    tick();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("pp_vld", 32'(out_valid), 32'd1);
    chk("pp_headC", out_data, 32'h000000C0);
    chk("pp_tagC", 32'(out_tag), 32'd5);
    chk("pp_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("pp_empty", 32'(out_valid), 32'd0);

    // Streaming 8 back to back, no bubble
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(i * 16'h0101), 2'd0, 5'(i));
      tick();
      chk($sformatf("stream%0d_vld", i), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d_dat", i), out_data, 32'(i * 32'h0101));
      chk($sformatf("stream%0d_tag", i), 32'(out_tag), 32'(i));
    end
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    tick();
    chk("stream_end", 32'(out_valid), 32'd0);

    // Flush with two entries plus a concurrent push
    out_ready = 1'b0;
    drive(1'b1, 16'h0E0E, 2'd0, 5'd6);
    tick();
    drive(1'b1, 16'h0F0F, 2'd0, 5'd7);
    tick();
    chk("fl_full", 32'(in_ready), 32'd0);
    drive(1'b1, 16'h0A0A, 2'd0, 5'd8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("fl_vld", 32'(out_valid), 32'd0);
    chk("fl_rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fl_gone%0d", i), 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-stream
    drive(1'b1, 16'h5555, 2'd1, 5'd10);
    out_ready = 1'b0;
    tick();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("ar_pre", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", 32'(out_valid), 32'd0);
    chk("ar_dat", out_data, 32'h0);
    chk("ar_tag", 32'(out_tag), 32'd0);
    chk("ar_rdy", 32'(in_ready), 32'd1);
    #3;
    rst_n = 1'b1;
    tick();
    chk("ar_after", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
